// File: rtl/inst_issue_ctrl.sv
// Instruction issue controller: selects one of NUM_SRC instruction sources and
// inserts wait cycles after bubble-enabled issues and on source changes.
module inst_issue_ctrl #(
  parameter int unsigned        NUM_SRC        = 2,
  parameter int unsigned        INST_W         = 32,
  parameter int unsigned        BUBBLE_CNT     = 3,
  parameter int unsigned        SWITCH_BUBBLES = 1,
  parameter logic [INST_W-1:0]  WAIT_INST      = '0,
  localparam int unsigned       SEL_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SEL_W-1:0]          src_sel_i,
  input  logic [NUM_SRC*INST_W-1:0] src_inst_i,
  input  logic [NUM_SRC-1:0]        bubble_en_i,
  input  logic                      stall_i,
  output logic [INST_W-1:0]         inst_o,
  output logic                      inst_valid_o,
  output logic                      bubble_o,
  output logic [SEL_W-1:0]          cur_src_o
);

  typedef enum logic {
    ISSUE  = 1'b0,
    BUBBLE = 1'b1
  } mode_e;

  localparam logic [3:0] BUBBLE_LD = 4'(BUBBLE_CNT);
  localparam logic [3:0] SWITCH_LD = 4'(SWITCH_BUBBLES - 1);

  logic [3:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [INST_W-1:0] src_arr [NUM_SRC];
  logic [SEL_W:0]   sel_ext;
  logic             sel_ok;
  logic             do_issue;
  mode_e            mode;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign src_arr[k] = src_inst_i[k*INST_W +: INST_W];
  end

  // Widened compare keeps the range check meaningful when NUM_SRC is a power of two.
  assign sel_ext   = {1'b0, src_sel_i};
  assign sel_ok    = (sel_ext < (SEL_W+1)'(NUM_SRC));
  assign mode      = (cnt_q != 4'd0) ? BUBBLE : ISSUE;
  assign bubble_o  = (mode == BUBBLE);
  assign cur_src_o = cur_sel_q;

  always_comb begin
    inst_o       = WAIT_INST;
    inst_valid_o = 1'b0;
    cnt_d        = cnt_q;
    cur_sel_d    = cur_sel_q;
    do_issue     = 1'b0;
    if (rst_i) begin
      cnt_d     = '0;
      cur_sel_d = '0;
    end else if (!stall_i) begin
      if (mode == BUBBLE) begin
        cnt_d = cnt_q - 4'd1;
      end else if (sel_ok) begin
        if (src_sel_i != cur_sel_q) begin
          cur_sel_d = src_sel_i;
          if (SWITCH_BUBBLES != 0) cnt_d = SWITCH_LD;
          else                     do_issue = 1'b1;
        end else begin
          do_issue = 1'b1;
        end
        if (do_issue) begin
          inst_o       = src_arr[src_sel_i];
          inst_valid_o = 1'b1;
          cnt_d        = (bubble_en_i[src_sel_i] && (BUBBLE_CNT != 0)) ? BUBBLE_LD : '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q     <= cnt_d;
    cur_sel_q <= cur_sel_d;
  end

endmodule
